// File: rtl/sram_1r1w_fifo_ctrl_if.sv
// Push/pop handshake bundle for sram_1r1w_fifo_ctrl.
// slave  : the FIFO controller side.
// master : the producer/consumer side.
interface sram_1r1w_fifo_ctrl_if #(
   parameter int DATA_WIDTH = 23,
   parameter int ADDR_WIDTH = 5
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic [ADDR_WIDTH:0]   count;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, count
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, count
   );
endinterface

// File: rtl/sram_1r1w_fifo_ctrl.sv
// FIFO controller around an external 1R1W SRAM macro (port 0 write, port 1 read).
// A 2-entry output buffer hides the macro's one-cycle read latency so both sides
// sustain 1 word/cycle. Capacity is DEPTH words in SRAM plus 2 in the buffer.
// Optional macro FIFO_BYPASS_EN: when nothing older sits in SRAM or in flight,
// a pushed word goes straight into the output buffer (1-cycle empty latency).
module sram_1r1w_fifo_ctrl #(
   parameter int DATA_WIDTH = 23,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                   clk,
   input  logic                   rst,
   sram_1r1w_fifo_ctrl_if.slave   bus,
   output logic                   sram_csb0,
   output logic [ADDR_WIDTH-1:0]  sram_addr0,
   output logic [DATA_WIDTH-1:0]  sram_din0,
   output logic                   sram_csb1,
   output logic [ADDR_WIDTH-1:0]  sram_addr1,
   input  logic [DATA_WIDTH-1:0]  sram_dout1
);
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

   logic [ADDR_WIDTH-1:0] r_wptr, r_rptr;
   logic [ADDR_WIDTH:0]   r_sram_cnt;
   logic                  r_inflight;
   logic [1:0]            r_ob_cnt;
   logic                  r_ob_hd;
   logic [DATA_WIDTH-1:0] r_ob [2];

   logic                  w_in_ready, w_push, w_pop, w_byp, w_wr, w_rd;
   logic                  w_ob_wr, w_tail;
   logic [1:0]            w_pend;
   logic [DATA_WIDTH-1:0] w_ob_din;

   // Handshake decode, prefetch decision and output-buffer write steering.
   always_comb begin
      w_in_ready = !rst && (r_sram_cnt < DEPTH_C);
      w_push     = bus.in_valid && w_in_ready;
      w_pop      = (r_ob_cnt != 2'd0) && bus.out_ready;
      // Buffer slots that will be claimed after this edge (held + in flight - leaving).
      w_pend     = r_ob_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
`ifdef FIFO_BYPASS_EN
      w_byp      = w_push && (r_sram_cnt == '0) && !r_inflight &&
                   ((r_ob_cnt - {1'b0, w_pop}) < 2'd2);
`else
      w_byp      = 1'b0;
`endif
      w_wr       = w_push && !w_byp;
      // sram_cnt>0 keeps the read off the address being written this cycle.
      w_rd       = !rst && (r_sram_cnt != '0) && (w_pend < 2'd2);
      // Capture and bypass are exclusive: bypass needs nothing in flight.
      w_ob_wr    = r_inflight || w_byp;
      w_ob_din   = r_inflight ? sram_dout1 : bus.in_data;
      // Tail = head + count (mod 2); with count 2 the tail is the slot being popped.
      w_tail     = r_ob_hd ^ r_ob_cnt[0];
   end

   // Pointer, occupancy and read-in-flight state.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_sram_cnt <= '0;
         r_inflight <= 1'b0;
         r_ob_cnt   <= 2'd0;
         r_ob_hd    <= 1'b0;
      end else begin
         if (w_wr) r_wptr <= r_wptr + ADDR_WIDTH'(1);
         if (w_rd) r_rptr <= r_rptr + ADDR_WIDTH'(1);
         r_sram_cnt <= r_sram_cnt + (ADDR_WIDTH+1)'(w_wr) - (ADDR_WIDTH+1)'(w_rd);
         // Read data is only valid at the edge ending the cycle after issue.
         r_inflight <= w_rd;
         r_ob_cnt   <= r_ob_cnt + 2'(w_ob_wr) - 2'(w_pop);
         if (w_pop) r_ob_hd <= ~r_ob_hd;
      end
   end

   // Output buffer storage; contents are qualified by r_ob_cnt so no reset.
   always_ff @(posedge clk) begin
      if (w_ob_wr) r_ob[w_tail] <= w_ob_din;
   end

   // Macro port and handshake outputs.
   always_comb begin
      bus.in_ready  = w_in_ready;
      bus.out_valid = (r_ob_cnt != 2'd0);
      bus.out_data  = r_ob[r_ob_hd];
      bus.count     = r_sram_cnt + (ADDR_WIDTH+1)'(r_inflight) + (ADDR_WIDTH+1)'(r_ob_cnt);
      sram_csb0     = !w_wr;
      sram_addr0    = r_wptr;
      sram_din0     = bus.in_data;
      sram_csb1     = !w_rd;
      sram_addr1    = r_rptr;
   end

`ifndef SYNTHESIS
   a_no_addr_collision: assert property (@(posedge clk) disable iff (rst)
      !(!sram_csb0 && !sram_csb1 && (sram_addr0 == sram_addr1)));
`endif
endmodule

// File: tb/tb_sram_1r1w_fifo_ctrl.sv
// Directed bench for sram_1r1w_fifo_ctrl with a behavioural 1R1W macro model.
// Honours FIFO_BYPASS_EN for the empty-FIFO latency expectations.
module tb_sram_1r1w_fifo_ctrl;
   localparam int DW = 23;
   localparam int AW = 5;
   localparam int DEPTH = 1 << AW;
`ifdef FIFO_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 3;
`endif
   // 0xABCDEF does not fit 23 bits; the word width keeps the low 23.
   localparam logic [DW-1:0] PAT_A = DW'(24'hABCDEF);
   localparam logic [DW-1:0] PAT_B = DW'(24'h123456);

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sram_1r1w_fifo_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();
   logic          sram_csb0, sram_csb1;
   logic [AW-1:0] sram_addr0, sram_addr1;
   logic [DW-1:0] sram_din0, sram_dout1;

   sram_1r1w_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .sram_csb0(sram_csb0), .sram_addr0(sram_addr0), .sram_din0(sram_din0),
      .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1)
   );

   // Macro model: sample at posedge, access at negedge, data X soon after next posedge.
   logic [DW-1:0] mem [DEPTH];
   logic          m_we = 1'b0, m_re = 1'b0;
   logic [AW-1:0] m_wa, m_ra;
   logic [DW-1:0] m_wd;
   initial sram_dout1 = 'x;
   always @(posedge clk) begin
      m_we = !sram_csb0; m_wa = sram_addr0; m_wd = sram_din0;
      m_re = !sram_csb1; m_ra = sram_addr1;
      #1 sram_dout1 = 'x;
   end
   always @(negedge clk) begin
      if (m_we) mem[m_wa] = m_wd;
      if (m_re) sram_dout1 = mem[m_ra];
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic set_in(input logic v, input logic [DW-1:0] d, input logic r);
      bus.in_valid = v; bus.in_data = d; bus.out_ready = r;
      #1;
   endtask

   task automatic tick;
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      set_in(1'b1, 23'h1, 1'b0);
      n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready got %b exp 0", bus.in_ready); end
      n_vec++; if (sram_csb0 !== 1'b1) begin n_err++; $display("FAIL rst_csb0 got %b exp 1", sram_csb0); end
      n_vec++; if (sram_csb1 !== 1'b1) begin n_err++; $display("FAIL rst_csb1 got %b exp 1", sram_csb1); end
      tick;
      set_in(1'b1, 23'h1, 1'b0);
      n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %b exp 0", bus.out_valid); end
      n_vec++; if (bus.count !== 6'd0) begin n_err++; $display("FAIL rst_count got %0d exp 0", bus.count); end
      n_vec++; if (sram_csb0 !== 1'b1) begin n_err++; $display("FAIL rst_csb0_held got %b exp 1", sram_csb0); end
      tick;
      rst = 1'b0;
      set_in(1'b0, '0, 1'b0);
      n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL idle_in_ready got %b exp 1", bus.in_ready); end
      n_vec++; if (sram_csb0 !== 1'b1 || sram_csb1 !== 1'b1) begin n_err++; $display("FAIL idle_csb got %b%b exp 11", sram_csb0, sram_csb1); end
      n_vec++; if (bus.out_valid !== 1'b0 || bus.count !== 6'd0) begin n_err++; $display("FAIL idle_empty got v=%b c=%0d exp v=0 c=0", bus.out_valid, bus.count); end
      tick;
   endtask

   task automatic test_fill_drain;
      for (int i = 1; i <= DEPTH + 2; i++) begin
         set_in(1'b1, DW'(i), 1'b0);
         n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL fill_ready word %0d got %b exp 1", i, bus.in_ready); end
         tick;
      end
      set_in(1'b1, DW'(DEPTH + 3), 1'b0);
      n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL full_ready got %b exp 0", bus.in_ready); end
      n_vec++; if (sram_csb0 !== 1'b1) begin n_err++; $display("FAIL full_csb0 got %b exp 1", sram_csb0); end
      n_vec++; if (bus.count !== 6'd34) begin n_err++; $display("FAIL full_count got %0d exp 34", bus.count); end
      n_vec++; if (bus.out_valid !== 1'b1 || bus.out_data !== 23'h1) begin n_err++; $display("FAIL full_head got v=%b d=%h exp v=1 d=000001", bus.out_valid, bus.out_data); end
      tick;
      for (int i = 1; i <= DEPTH + 2; i++) begin
         set_in(1'b0, '0, 1'b1);
         n_vec++; if (bus.out_valid !== 1'b1 || bus.out_data !== DW'(i)) begin n_err++; $display("FAIL drain word %0d got v=%b d=%h exp v=1 d=%h", i, bus.out_valid, bus.out_data, DW'(i)); end
         tick;
      end
      set_in(1'b0, '0, 1'b0);
      n_vec++; if (bus.out_valid !== 1'b0 || bus.count !== 6'd0) begin n_err++; $display("FAIL drained got v=%b c=%0d exp v=0 c=0", bus.out_valid, bus.count); end
      tick;
   endtask

   task automatic test_latency;
      set_in(1'b1, 23'h5A5A5A, 1'b0);
      n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL lat_ready got %b exp 1", bus.in_ready); end
      tick;
      for (int k = 1; k <= LAT; k++) begin
         set_in(1'b0, '0, 1'b0);
         n_vec++; if (bus.out_valid !== (k == LAT)) begin n_err++; $display("FAIL lat_valid cycle %0d got %b exp %b", k, bus.out_valid, (k == LAT)); end
         if (k == LAT) begin
            n_vec++; if (bus.out_data !== 23'h5A5A5A) begin n_err++; $display("FAIL lat_data got %h exp 5a5a5a", bus.out_data); end
         end
         tick;
      end
      set_in(1'b0, '0, 1'b1);
      tick;
      set_in(1'b0, '0, 1'b0);
      n_vec++; if (bus.count !== 6'd0) begin n_err++; $display("FAIL lat_empty got %0d exp 0", bus.count); end
      tick;
   endtask

   task automatic test_back_to_back;
      int sent = 0, got = 0, first = -1, last = -1;
      for (int c = 0; c < 300 && got < 100; c++) begin
         set_in(sent < 100, DW'(32'h1000 + sent), 1'b1);
         if (bus.out_valid) begin
            n_vec++; if (bus.out_data !== DW'(32'h1000 + got)) begin n_err++; $display("FAIL stream_data idx %0d got %h exp %h", got, bus.out_data, DW'(32'h1000 + got)); end
            if (first < 0) first = c;
            last = c;
            got++;
         end
         if (bus.in_valid && bus.in_ready) sent++;
         tick;
      end
      n_vec++; if (got !== 100) begin n_err++; $display("FAIL stream_count got %0d exp 100", got); end
      n_vec++; if (first !== LAT) begin n_err++; $display("FAIL stream_first got cycle %0d exp %0d", first, LAT); end
      n_vec++; if (last - first !== 99) begin n_err++; $display("FAIL stream_rate got span %0d exp 99", last - first); end
   endtask

   task automatic test_random;
      logic [DW-1:0] q[$];
      logic [DW-1:0] nxt = 23'h200000;
      logic [AW:0]   exp_cnt;
      logic          v, r;
      for (int c = 0; c < 2000; c++) begin
         v = 1'($urandom_range(0, 1));
         r = 1'($urandom_range(0, 1));
         set_in(v, nxt, r);
         exp_cnt = (AW+1)'(q.size());
         n_vec++; if (bus.count !== exp_cnt) begin n_err++; $display("FAIL rand_count cycle %0d got %0d exp %0d", c, bus.count, exp_cnt); end
         if (bus.out_valid && r) begin
            n_vec++;
            if (q.size() == 0) begin n_err++; $display("FAIL rand_pop_empty cycle %0d got %h exp no word", c, bus.out_data); end
            else begin
               if (bus.out_data !== q[0]) begin n_err++; $display("FAIL rand_data cycle %0d got %h exp %h", c, bus.out_data, q[0]); end
               void'(q.pop_front());
            end
         end
         if (v && bus.in_ready) begin q.push_back(nxt); nxt++; end
         tick;
      end
      for (int c = 0; c < 60 && q.size() != 0; c++) begin
         set_in(1'b0, '0, 1'b1);
         if (bus.out_valid) begin
            n_vec++; if (bus.out_data !== q[0]) begin n_err++; $display("FAIL rand_drain got %h exp %h", bus.out_data, q[0]); end
            void'(q.pop_front());
         end
         tick;
      end
      set_in(1'b0, '0, 1'b0);
      n_vec++; if (q.size() != 0 || bus.count !== 6'd0) begin n_err++; $display("FAIL rand_final got q=%0d c=%0d exp 0 0", q.size(), bus.count); end
      tick;
   endtask

   task automatic test_reset_mid;
      logic [DW-1:0] g[$];
      for (int i = 0; i < 11; i++) begin set_in(1'b1, DW'(32'h300 + i), 1'b0); tick; end
      for (int i = 0; i < 4; i++) begin set_in(1'b0, '0, 1'b0); tick; end
      set_in(1'b0, '0, 1'b1);
      n_vec++; if (bus.out_data !== 23'h300) begin n_err++; $display("FAIL mid_head got %h exp 000300", bus.out_data); end
      n_vec++; if (sram_csb1 !== 1'b0) begin n_err++; $display("FAIL mid_read_issue got csb1=%b exp 0", sram_csb1); end
      tick;
      rst = 1'b1;
      set_in(1'b0, '0, 1'b0);
      n_vec++; if (bus.count !== 6'd10) begin n_err++; $display("FAIL mid_count_pre got %0d exp 10", bus.count); end
      tick;
      rst = 1'b0;
      set_in(1'b0, '0, 1'b0);
      n_vec++; if (bus.count !== 6'd0 || bus.out_valid !== 1'b0) begin n_err++; $display("FAIL mid_after_rst got c=%0d v=%b exp c=0 v=0", bus.count, bus.out_valid); end
      tick;
      for (int c = 0; c < 22; c++) begin
         set_in(c < 2, (c == 0) ? PAT_A : PAT_B, 1'b1);
         if (bus.out_valid) g.push_back(bus.out_data);
         tick;
      end
      n_vec++; if (g.size() != 2) begin n_err++; $display("FAIL mid_pop_count got %0d exp 2", g.size()); end
      else begin
         n_vec++; if (g[0] !== PAT_A) begin n_err++; $display("FAIL mid_first got %h exp %h", g[0], PAT_A); end
         n_vec++; if (g[1] !== PAT_B) begin n_err++; $display("FAIL mid_second got %h exp %h", g[1], PAT_B); end
      end
      set_in(1'b0, '0, 1'b0);
      n_vec++; if (bus.count !== 6'd0) begin n_err++; $display("FAIL mid_final got %0d exp 0", bus.count); end
      tick;
   endtask

   initial begin
      bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
      @(posedge clk); #1;
      test_reset;
      test_fill_drain;
      test_latency;
      test_back_to_back;
      test_random;
      test_reset_mid;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/sram_1r1w_fifo_ctrl.md
Name: sram_1r1w_fifo_ctrl

Overview:
- Synchronous FIFO controller that sequences one external 1R1W SRAM macro (write port 0, read port 1) as FIFO storage. Defaults match the 23-bit x 32-word macro.
- Presents a valid/ready push interface and a first-word-fall-through valid/ready pop interface.
- Hides the macro's one-cycle read latency behind a 2-entry output buffer, so sustained throughput is 1 word/cycle in each direction.

Parameters:
- DATA_WIDTH, 23, word width; must equal the macro word size.
- ADDR_WIDTH, 5, macro address width.
- DEPTH, 1<<ADDR_WIDTH, number of SRAM words; derived, not overridden.

Ports:
- clk  input  1  single clock; the macro's clk0 and clk1 are tied to it.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  push request.
- in_ready  output  1  push accepted when in_valid && in_ready.
- in_data  input  DATA_WIDTH  push data.
- out_valid  output  1  head word available.
- out_ready  input  1  pop when out_valid && out_ready.
- out_data  output  DATA_WIDTH  head word.
- count  output  ADDR_WIDTH+1  total words held (SRAM + in-flight + output buffer).
- sram_csb0  output  1  macro write chip select, active low.
- sram_addr0  output  ADDR_WIDTH  macro write address.
- sram_din0  output  DATA_WIDTH  macro write data.
- sram_csb1  output  1  macro read chip select, active low.
- sram_addr1  output  ADDR_WIDTH  macro read address.
- sram_dout1  input  DATA_WIDTH  macro read data.

Behaviour:
- Macro timing:
  - The macro samples csb/addr/din at a posedge. It writes and reads at the following negedge.
  - Read data from a request issued in cycle N is valid only at the posedge ending cycle N+1. It goes X shortly after that edge, so the controller must capture it at exactly that edge.
- State:
  - wptr and rptr (ADDR_WIDTH bits, natural wrap at DEPTH).
  - sram_cnt (0..DEPTH).
  - inflight (1 bit).
  - ob: 2-entry output buffer with ob_cnt 0..2.
- Reset:
  - Clears wptr, rptr, sram_cnt, inflight and ob_cnt.
  - Outputs during and after reset: in_ready=0 while rst is high, then 1. out_valid=0. count=0. sram_csb0=sram_csb1=1. out_data and the addr/din outputs are don't-care.
  - SRAM contents are not cleared. An in-flight read is discarded.
  - Reset asserted mid-operation takes effect at the next edge; all queued data is lost.
- Push:
  - in_ready = !rst && (sram_cnt < DEPTH).
  - On accept, in the same cycle, drive sram_csb0=0, sram_addr0=wptr, sram_din0=in_data combinationally. At the edge, wptr+1 and sram_cnt+1.
  - The write is not visible to reads until the cycle after acceptance.
- Prefetch read:
  - Issue in cycle N when !rst && sram_cnt>0 && (ob_cnt + inflight - pop_now) < 2.
  - pop_now = out_valid && out_ready.
  - Drive sram_csb1=0 and sram_addr1=rptr. At the edge, rptr+1, sram_cnt-1, inflight=1.
  - At the end of cycle N+1, write sram_dout1 into the ob tail and clear inflight, unless a new read is issued.
- Simultaneous push and read at the same edge: sram_cnt is unchanged.
- Address-collision rule: sram_csb0 and sram_csb1 are never both low with sram_addr0 == sram_addr1. The guard sram_cnt>0 on reads and sram_cnt<DEPTH on writes guarantees this; a simulation assertion checks it.
- Pop:
  - out_valid = (ob_cnt > 0). out_data = ob head.
  - On pop, the head advances. A capture and a pop at the same edge keep ob_cnt.
- Latency: a push into an empty FIFO gives out_valid 3 cycles later (write, read, capture).
- Capacity and count:
  - Total capacity is DEPTH + 2. in_ready depends only on sram_cnt, so up to DEPTH+2 words can be held.
  - count = sram_cnt + inflight + ob_cnt, registered-value sum.
- Ordering: strict FIFO order across pointer wrap-around.
- Throughput: with out_ready held at 1 and continuous pushes, 1 word/cycle.

Optional Feature:
- Macro: FIFO_BYPASS_EN.
- Defined:
  - When sram_cnt==0, inflight==0, ob_cnt - pop_now < 2 and a push is accepted, in_data goes directly into the ob tail.
  - No SRAM write occurs (sram_csb0 stays 1) and wptr/rptr are unchanged.
  - Empty-FIFO latency becomes 1 cycle. Ordering is preserved because the bypass fires only when nothing older is in SRAM or in flight.
- Undefined: no bypass; every word passes through the SRAM; latency 3.

Test Plan:
- Reset then idle: csb0=csb1=1, out_valid=0, count=0, in_ready=1 one cycle after rst drops.
- Push 0x000001..0x000022 (34 words) with out_ready=0:
  - in_ready falls after the 32nd SRAM word.
  - count=34 and ob holds 0x000001 and 0x000002.
  - Then drain with out_ready=1 and receive 1..34 in order with no gaps.
- Single push 0x5A5A5A into an empty FIFO: out_valid rises 3 cycles later (1 cycle with FIFO_BYPASS_EN) and out_data=0x5A5A5A.
- Stream 100 sequential words with both sides always ready:
  - Pointers wrap at least 3 times.
  - Output equals input order at 1 word/cycle in steady state.
  - The collision assertion never fires.
- Random in_valid/out_ready (50%) for 2000 cycles against a scoreboard: no loss, no duplication, count always matches the scoreboard.
- Assert rst for 1 cycle while a read is in flight and count=10: the next cycle gives count=0 and out_valid=0. Subsequent pushes of 0xABCDEF and 0x123456 emerge in order, with no stale data.
